// File: rtl/local_mem_pkg.sv
// Shared types, constants and the address-derived pattern used by the local memory model.
package local_mem_pkg;

  localparam int WR_CNT_W   = 16;
  localparam int MAX_RD_LAT = 4;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // One byte lane of the pattern word; callers loop over DATA_W/8 lanes.
  function automatic logic [7:0] pattern_lane(input logic [6:0] word_addr, input int lane);
    logic [6:0] sum;
    sum = word_addr + 7'(lane);
    return {1'b0, sum};
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// DEPTH-stage valid/data delay line with synchronous clear; the last stage holds its data between beats.
module mem_rd_pipe #(
  parameter int DEPTH = 1,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [W-1:0]     data_q [DEPTH];
  logic [W-1:0]     data_d [DEPTH];

  // NOTE: every always_comb output gets a value on every path first, so no latch is inferred.
  always_comb begin
    vld_d[0]  = in_vld;
    data_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i]  = vld_q[i-1];
      data_d[i] = data_q[i-1];
    end
    if (!vld_d[DEPTH-1]) data_d[DEPTH-1] = data_q[DEPTH-1];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign out_vld  = vld_q[DEPTH-1];
  assign out_data = data_q[DEPTH-1];

endmodule

// File: rtl/local_mem_model.sv
// Byte-enabled local memory behind BAR decode: init sweep, pattern read mode,
// pipelined reads with a valid strobe and a saturating write counter.
module local_mem_model
  import local_mem_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 10,
  parameter int RD_LAT       = 1,
  parameter int INIT_PATTERN = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     dout,
  output logic                  dout_vld,
  output logic                  init_busy,
  output logic [WR_CNT_W-1:0]   wr_cnt
);

  localparam int LANES     = DATA_W / 8;
  localparam int MEM_DEPTH = 2 ** ADDR_W;
  localparam int LAT       = (RD_LAT < 1) ? 1 : ((RD_LAT > MAX_RD_LAT) ? MAX_RD_LAT : RD_LAT);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   init_addr_q, init_addr_d;
  logic [WR_CNT_W-1:0] wr_cnt_q, wr_cnt_d;

  logic [DATA_W-1:0]   mem [MEM_DEPTH];
  logic                mem_we;
  logic [LANES-1:0]    mem_be;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   pat_word, init_word, rd_word;
  logic                rd_vld;

  always_comb begin
    pat_word  = '0;
    init_word = '0;
    for (int k = 0; k < LANES; k++) begin
      pat_word[8*k +: 8]  = pattern_lane(7'(addr), k);
      init_word[8*k +: 8] = pattern_lane(7'(init_addr_q), k);
    end
  end

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    wr_cnt_d    = wr_cnt_q;
    mem_we      = 1'b0;
    mem_be      = '0;
    mem_addr    = addr;
    mem_wdata   = din;
    rd_vld      = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        // User strobes are ignored while the sweep owns the RAM port.
        mem_we      = 1'b1;
        mem_be      = '1;
        mem_addr    = init_addr_q;
        mem_wdata   = (INIT_PATTERN != 0) ? init_word : '0;
        init_addr_d = init_addr_q + ADDR_W'(1);
        if (init_addr_q == '1) state_d = ST_RUN;
      end
      ST_RUN: begin
        mem_we = we;
        mem_be = be;
        rd_vld = re;
        if (we && (wr_cnt_q != '1)) wr_cnt_d = wr_cnt_q + WR_CNT_W'(1);
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      wr_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      wr_cnt_q    <= wr_cnt_d;
    end
  end

  // NOTE: the RAM array has no reset; the post-reset sweep gives it defined contents.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int k = 0; k < LANES; k++) begin
        if (mem_be[k]) mem[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
      end
    end
  end

  // Read-first: the pipe captures the pre-write word on the same edge the write lands.
  assign rd_word = mode ? pat_word : mem[addr];

  mem_rd_pipe #(
    .DEPTH (LAT),
    .W     (DATA_W)
  ) u_rd_pipe (
    .clk      (clk),
    .clr      (rst),
    .in_vld   (rd_vld),
    .in_data  (rd_word),
    .out_vld  (dout_vld),
    .out_data (dout)
  );

  assign init_busy = (state_q == ST_INIT);
  assign wr_cnt    = wr_cnt_q;

endmodule

// File: tb/tb_local_mem_model.sv
// Drives two local_mem_model instances (read latency 1 and 3) with shared stimulus and
// scores their read beats and counters against an array/queue reference model.
module tb_local_mem_model;

  localparam int NWORDS = 1024;

  logic        clk = 1'b0;
  logic        rst, mode, we, re;
  logic [3:0]  be;
  logic [9:0]  addr;
  logic [31:0] din;

  logic [31:0] dout1, dout3;
  logic        vld1, vld3, busy1, busy3;
  logic [15:0] wcnt1, wcnt3;

  always #5 clk = ~clk;

  local_mem_model #(.DATA_W(32), .ADDR_W(10), .RD_LAT(1), .INIT_PATTERN(1)) u_lat1 (
    .clk(clk), .rst(rst), .mode(mode), .we(we), .be(be), .re(re), .addr(addr), .din(din),
    .dout(dout1), .dout_vld(vld1), .init_busy(busy1), .wr_cnt(wcnt1)
  );

  local_mem_model #(.DATA_W(32), .ADDR_W(10), .RD_LAT(3), .INIT_PATTERN(1)) u_lat3 (
    .clk(clk), .rst(rst), .mode(mode), .we(we), .be(be), .re(re), .addr(addr), .din(din),
    .dout(dout3), .dout_vld(vld3), .init_busy(busy3), .wr_cnt(wcnt3)
  );

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } beat_t;

  beat_t       exp1[$], exp3[$], got1[$], got3[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          vld_in_init = 0;
  logic [31:0] ref_mem [NWORDS];
  int          wr_model = 0;
  int          init_left = NWORDS;

  always @(posedge clk) cyc <= cyc + 1;

  // Recorder only: captures returned beats for the scenario tasks to score.
  always @(negedge clk) begin
    if (vld1) got1.push_back('{cyc, dout1});
    if (vld3) got3.push_back('{cyc, dout3});
    if ((vld1 && busy1) || (vld3 && busy3)) vld_in_init++;
  end

  function automatic logic [31:0] pat(input int a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'(((a % 128) + k) % 128);
    return w;
  endfunction

  // Applies one cycle of stimulus (called at a negedge) and advances the model.
  task automatic drive(input logic w, input logic [3:0] b, input logic r, input logic m,
                       input logic [9:0] a, input logic [31:0] d);
    we = w; be = b; re = r; mode = m; addr = a; din = d;
    if (init_left == 0) begin
      if (r) begin
        exp1.push_back('{cyc + 1, m ? pat(int'(a)) : ref_mem[a]});
        exp3.push_back('{cyc + 3, m ? pat(int'(a)) : ref_mem[a]});
      end
      if (w) begin
        for (int k = 0; k < 4; k++) if (b[k]) ref_mem[a][8*k +: 8] = d[8*k +: 8];
        if (wr_model < 65535) wr_model++;
      end
    end else begin
      init_left--;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 4'h0, 1'b0, 1'b0, 10'h0, 32'h0);
  endtask

  // Two-cycle reset; beats due on or after the reset edge are dropped from the model.
  task automatic apply_reset();
    int r;
    rst = 1'b1; we = 1'b0; re = 1'b0; mode = 1'b0; be = 4'h0; addr = 10'h0; din = 32'h0;
    r = cyc + 1;
    for (int i = exp1.size() - 1; i >= 0; i--) if (exp1[i].cyc >= r) exp1.delete(i);
    for (int i = exp3.size() - 1; i >= 0; i--) if (exp3[i].cyc >= r) exp3.delete(i);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NWORDS; i++) ref_mem[i] = pat(i);
    wr_model  = 0;
    init_left = NWORDS;
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if ({dout1, vld1, busy1, wcnt1} !== {32'h0, 1'b0, 1'b1, 16'h0}) begin
      bad++;
      $display("FAIL reset lat1: dout=%h vld=%b busy=%b wcnt=%h want 0/0/1/0", dout1, vld1, busy1, wcnt1);
    end
    total++;
    if ({dout3, vld3, busy3, wcnt3} !== {32'h0, 1'b0, 1'b1, 16'h0}) begin
      bad++;
      $display("FAIL reset lat3: dout=%h vld=%b busy=%b wcnt=%h want 0/0/1/0", dout3, vld3, busy3, wcnt3);
    end
  endtask

  // Counts init_busy cycles from reset release while issuing reads that must be ignored.
  task automatic test_init(input string name);
    int n1, n3, n;
    n1 = 0; n3 = 0; n = 0;
    vld_in_init = 0;
    while ((busy1 || busy3) && n < 2000) begin
      if (busy1) n1++;
      if (busy3) n3++;
      n++;
      drive(1'b0, 4'h0, 1'b1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, NWORDS - 1)), 32'h0);
    end
    total++;
    if (n1 != NWORDS) begin bad++; $display("FAIL %s busy lat1: %0d cycles want %0d", name, n1, NWORDS); end
    total++;
    if (n3 != NWORDS) begin bad++; $display("FAIL %s busy lat3: %0d cycles want %0d", name, n3, NWORDS); end
    total++;
    if (vld_in_init != 0 || got1.size() != 0 || got3.size() != 0) begin
      bad++;
      $display("FAIL %s vld during init: saw %0d/%0d/%0d beats want 0", name, vld_in_init, got1.size(), got3.size());
    end
    got1.delete(); got3.delete();
  endtask

  task automatic test_preload_read();
    beat_t g, e;
    beat_t eq[$], gq[$];
    drive(1'b0, 4'h0, 1'b1, 1'b0, 10'h005, 32'h0);
    drive(1'b0, 4'h0, 1'b1, 1'b1, 10'h005, 32'h0);
    idle(6);
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin eq = exp1; gq = got1; end else begin eq = exp3; gq = got3; end
      total++;
      if (gq.size() != eq.size()) begin bad++; $display("FAIL preload lat%0d beats: got %0d want %0d", d ? 3 : 1, gq.size(), eq.size()); end
      while (gq.size() > 0 && eq.size() > 0) begin
        g = gq.pop_front(); e = eq.pop_front();
        total++;
        if (g.data !== e.data || g.cyc != e.cyc) begin bad++; $display("FAIL preload lat%0d read: got %h@%0d want %h@%0d", d ? 3 : 1, g.data, g.cyc, e.data, e.cyc); end
      end
    end
    exp1.delete(); exp3.delete(); got1.delete(); got3.delete();
  endtask

  task automatic test_byte_write();
    beat_t g, e;
    beat_t eq[$], gq[$];
    logic [31:0] last;
    drive(1'b1, 4'b0101, 1'b0, 1'b0, 10'h010, 32'hDEADBEEF);
    drive(1'b0, 4'h0, 1'b1, 1'b0, 10'h010, 32'h0);
    drive(1'b0, 4'h0, 1'b1, 1'b1, 10'h010, 32'h0);
    idle(6);
    last = exp1[exp1.size() - 1].data;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin eq = exp1; gq = got1; end else begin eq = exp3; gq = got3; end
      total++;
      if (gq.size() != eq.size()) begin bad++; $display("FAIL bytewr lat%0d beats: got %0d want %0d", d ? 3 : 1, gq.size(), eq.size()); end
      while (gq.size() > 0 && eq.size() > 0) begin
        g = gq.pop_front(); e = eq.pop_front();
        total++;
        if (g.data !== e.data || g.cyc != e.cyc) begin bad++; $display("FAIL bytewr lat%0d read: got %h@%0d want %h@%0d", d ? 3 : 1, g.data, g.cyc, e.data, e.cyc); end
      end
    end
    exp1.delete(); exp3.delete(); got1.delete(); got3.delete();
    total++;
    if (wcnt1 !== 16'(wr_model) || wcnt3 !== 16'(wr_model)) begin
      bad++; $display("FAIL bytewr wr_cnt: got %0d/%0d want %0d", wcnt1, wcnt3, wr_model);
    end
    total++;
    if (dout1 !== last || dout3 !== last) begin
      bad++; $display("FAIL dout hold: got %h/%h want %h", dout1, dout3, last);
    end
  endtask

  task automatic test_read_first();
    beat_t g, e;
    beat_t eq[$], gq[$];
    drive(1'b1, 4'hF, 1'b1, 1'b0, 10'h020, 32'hFFFFFFFF);
    drive(1'b0, 4'h0, 1'b1, 1'b0, 10'h020, 32'h0);
    idle(6);
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin eq = exp1; gq = got1; end else begin eq = exp3; gq = got3; end
      total++;
      if (gq.size() != eq.size()) begin bad++; $display("FAIL rdfirst lat%0d beats: got %0d want %0d", d ? 3 : 1, gq.size(), eq.size()); end
      while (gq.size() > 0 && eq.size() > 0) begin
        g = gq.pop_front(); e = eq.pop_front();
        total++;
        if (g.data !== e.data || g.cyc != e.cyc) begin bad++; $display("FAIL rdfirst lat%0d read: got %h@%0d want %h@%0d", d ? 3 : 1, g.data, g.cyc, e.data, e.cyc); end
      end
    end
    exp1.delete(); exp3.delete(); got1.delete(); got3.delete();
  endtask

  task automatic test_back_to_back();
    beat_t g, e;
    beat_t eq[$], gq[$];
    drive(1'b0, 4'h0, 1'b1, 1'b0, 10'h07E, 32'h0);
    drive(1'b0, 4'h0, 1'b1, 1'b0, 10'h07F, 32'h0);
    drive(1'b0, 4'h0, 1'b1, 1'b1, 10'h080, 32'h0);
    drive(1'b0, 4'h0, 1'b1, 1'b0, 10'h3FF, 32'h0);
    idle(8);
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin eq = exp1; gq = got1; end else begin eq = exp3; gq = got3; end
      total++;
      if (gq.size() != eq.size()) begin bad++; $display("FAIL b2b lat%0d beats: got %0d want %0d", d ? 3 : 1, gq.size(), eq.size()); end
      while (gq.size() > 0 && eq.size() > 0) begin
        g = gq.pop_front(); e = eq.pop_front();
        total++;
        if (g.data !== e.data || g.cyc != e.cyc) begin bad++; $display("FAIL b2b lat%0d read: got %h@%0d want %h@%0d", d ? 3 : 1, g.data, g.cyc, e.data, e.cyc); end
      end
    end
    exp1.delete(); exp3.delete(); got1.delete(); got3.delete();
  endtask

  // Random mix over a small address window so writes, reads and mode changes collide often.
  task automatic test_random();
    beat_t g, e;
    beat_t eq[$], gq[$];
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 10'(10'h3F8 + $urandom_range(0, 11)), $urandom);
    end
    idle(8);
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin eq = exp1; gq = got1; end else begin eq = exp3; gq = got3; end
      total++;
      if (gq.size() != eq.size()) begin bad++; $display("FAIL random lat%0d beats: got %0d want %0d", d ? 3 : 1, gq.size(), eq.size()); end
      while (gq.size() > 0 && eq.size() > 0) begin
        g = gq.pop_front(); e = eq.pop_front();
        total++;
        if (g.data !== e.data || g.cyc != e.cyc) begin bad++; $display("FAIL random lat%0d read: got %h@%0d want %h@%0d", d ? 3 : 1, g.data, g.cyc, e.data, e.cyc); end
      end
    end
    exp1.delete(); exp3.delete(); got1.delete(); got3.delete();
    total++;
    if (wcnt1 !== 16'(wr_model) || wcnt3 !== 16'(wr_model)) begin
      bad++; $display("FAIL random wr_cnt: got %0d/%0d want %0d", wcnt1, wcnt3, wr_model);
    end
  endtask

  task automatic test_reset_midflight();
    beat_t g, e;
    beat_t eq[$], gq[$];
    drive(1'b0, 4'h0, 1'b1, 1'b0, 10'h010, 32'h0);
    drive(1'b0, 4'h0, 1'b1, 1'b0, 10'h020, 32'h0);
    apply_reset();
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin eq = exp1; gq = got1; end else begin eq = exp3; gq = got3; end
      total++;
      if (gq.size() != eq.size()) begin bad++; $display("FAIL flush lat%0d beats: got %0d want %0d", d ? 3 : 1, gq.size(), eq.size()); end
      while (gq.size() > 0 && eq.size() > 0) begin
        g = gq.pop_front(); e = eq.pop_front();
        total++;
        if (g.data !== e.data || g.cyc != e.cyc) begin bad++; $display("FAIL flush lat%0d read: got %h@%0d want %h@%0d", d ? 3 : 1, g.data, g.cyc, e.data, e.cyc); end
      end
    end
    exp1.delete(); exp3.delete(); got1.delete(); got3.delete();
    total++;
    if (wcnt1 !== 16'h0 || wcnt3 !== 16'h0 || dout1 !== 32'h0 || dout3 !== 32'h0) begin
      bad++; $display("FAIL flush state: wcnt=%0d/%0d dout=%h/%h want 0", wcnt1, wcnt3, dout1, dout3);
    end
    test_init("reinit");
    // Previously written words must read back as the re-swept pattern.
    drive(1'b0, 4'h0, 1'b1, 1'b0, 10'h010, 32'h0);
    drive(1'b0, 4'h0, 1'b1, 1'b0, 10'h020, 32'h0);
    idle(6);
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin eq = exp1; gq = got1; end else begin eq = exp3; gq = got3; end
      total++;
      if (gq.size() != eq.size()) begin bad++; $display("FAIL resweep lat%0d beats: got %0d want %0d", d ? 3 : 1, gq.size(), eq.size()); end
      while (gq.size() > 0 && eq.size() > 0) begin
        g = gq.pop_front(); e = eq.pop_front();
        total++;
        if (g.data !== e.data || g.cyc != e.cyc) begin bad++; $display("FAIL resweep lat%0d read: got %h@%0d want %h@%0d", d ? 3 : 1, g.data, g.cyc, e.data, e.cyc); end
      end
    end
    exp1.delete(); exp3.delete(); got1.delete(); got3.delete();
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; mode = 1'b0; be = 4'h0; addr = 10'h0; din = 32'h0;
    @(negedge clk);
    test_reset();
    test_init("init");
    test_preload_read();
    test_byte_write();
    test_read_first();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
